// File: rtl/spi_transaction_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_transaction_fsm_if
// Purpose  : Handshake bundle between the SPI front end and the transaction FSM.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_transaction_fsm_if;
  logic sclkPosEdge;
  logic csConditioned;
  logic rwBit;
  logic srParallelLoad;
  logic addrWriteEnable;
  logic dmWriteEnable;
  logic misoBufferEnable;
  logic busy;

  modport master (
    output sclkPosEdge, csConditioned, rwBit,
    input  srParallelLoad, addrWriteEnable, dmWriteEnable, misoBufferEnable, busy
  );

  modport slave (
    input  sclkPosEdge, csConditioned, rwBit,
    output srParallelLoad, addrWriteEnable, dmWriteEnable, misoBufferEnable, busy
  );
endinterface
`default_nettype wire

// File: rtl/spi_transaction_fsm.sv
`default_nettype none
// ============================================================================
// Module   : spi_transaction_fsm
// Purpose  : Sequences address capture, memory read/write and MISO drive.
// Revision : 1.0 - initial release
// ============================================================================
module spi_transaction_fsm #(
  parameter int WIDTH       = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  wire logic            clk,
  input  wire logic            reset,
  spi_transaction_fsm_if.slave bus
);

  localparam int                 c_BIT_W     = $clog2(WIDTH + 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(WIDTH - 1);
  localparam logic [3:0]         c_LAST_WAIT = 4'(WAIT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    GET_ADDR  = 4'd1,
    GOT_ADDR  = 4'd2,
    READ_WAIT = 4'd3,
    READ_LOAD = 4'd4,
    READ_SEND = 4'd5,
    WRITE_GET = 4'd6,
    WRITE_DM  = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [c_BIT_W-1:0] r_bitCount;
  logic [c_BIT_W-1:0] w_bitCountNext;
  logic [3:0]         r_waitCount;
  logic [3:0]         w_waitCountNext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_bitCount  <= '0;
      r_waitCount <= '0;
    end else begin
      r_state     <= w_nextState;
      r_bitCount  <= w_bitCountNext;
      r_waitCount <= w_waitCountNext;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_bitCountNext  = r_bitCount;
    w_waitCountNext = r_waitCount;

    // Deselect aborts any transaction ahead of every other transition.
    if (r_state != IDLE && bus.csConditioned) begin
      w_nextState     = IDLE;
      w_bitCountNext  = '0;
      w_waitCountNext = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!bus.csConditioned) begin
            w_nextState    = GET_ADDR;
            w_bitCountNext = '0;
          end
        end
        GET_ADDR, WRITE_GET, READ_SEND: begin
          if (bus.sclkPosEdge) begin
            if (r_bitCount == c_LAST_BIT) begin
              w_bitCountNext = '0;
              case (r_state)
                GET_ADDR:  w_nextState = GOT_ADDR;
                WRITE_GET: w_nextState = WRITE_DM;
                default:   w_nextState = DONE;
              endcase
            end else begin
              w_bitCountNext = r_bitCount + c_BIT_W'(1);
            end
          end
        end
        GOT_ADDR: begin
          w_nextState     = bus.rwBit ? READ_WAIT : WRITE_GET;
          w_waitCountNext = '0;
        end
        READ_WAIT: begin
          if (r_waitCount == c_LAST_WAIT) begin
            w_nextState     = READ_LOAD;
            w_waitCountNext = '0;
          end else begin
            w_waitCountNext = r_waitCount + 4'd1;
          end
        end
        READ_LOAD: begin
          w_nextState    = READ_SEND;
          w_bitCountNext = '0;
        end
        WRITE_DM: w_nextState = DONE;
        DONE:     w_nextState = DONE;
        default: begin
          w_nextState     = IDLE;
          w_bitCountNext  = '0;
          w_waitCountNext = '0;
        end
      endcase
    end
  end

  assign bus.addrWriteEnable  = (r_state == GOT_ADDR);
  assign bus.srParallelLoad   = (r_state == READ_LOAD);
  assign bus.misoBufferEnable = (r_state == READ_SEND);
  assign bus.dmWriteEnable    = (r_state == WRITE_DM);
  assign bus.busy             = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_transaction_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_transaction_fsm
// Purpose  : Scoreboard bench for spi_transaction_fsm (WAIT_CYCLES 1 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_transaction_fsm;
  localparam int WIDTH  = 8;
  localparam int GAP    = 20;
  localparam int K_ADDR = 1;
  localparam int K_LOAD = 2;
  localparam int K_MISO = 3;
  localparam int K_DM   = 4;

  typedef struct packed { int kind; int cyc; } ev_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cs    = 1'b1;
  logic sclk  = 1'b0;
  logic rw    = 1'b0;
  int   cyc     = 0;
  int   nChecks = 0;
  int   nPass   = 0;
  ev_t  q0[$];
  ev_t  q1[$];

  spi_transaction_fsm_if busA();
  spi_transaction_fsm_if busB();

  assign busA.sclkPosEdge   = sclk;
  assign busA.csConditioned = cs;
  assign busA.rwBit         = rw;
  assign busB.sclkPosEdge   = sclk;
  assign busB.csConditioned = cs;
  assign busB.rwBit         = rw;

  spi_transaction_fsm #(.WIDTH(WIDTH), .WAIT_CYCLES(1)) dutA (.clk(clk), .reset(reset), .bus(busA));
  spi_transaction_fsm #(.WIDTH(WIDTH), .WAIT_CYCLES(3)) dutB (.clk(clk), .reset(reset), .bus(busB));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkValue(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushEv(input int idx, input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    if (idx == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic pushBoth(input int kind, input int c);
    pushEv(0, kind, c);
    pushEv(1, kind, c);
  endtask

  // Any asserted enable must match the next expected event, both in kind and cycle.
  task automatic monitorOne(input int idx, input logic a, input logic l, input logic m, input logic d);
    logic [3:0] vec;
    int kind;
    ev_t e;
    vec = {d, m, l, a};
    if (vec != 4'b0000) begin
      checkValue($sformatf("dut%0d.oneHot", idx), $countones(vec), 1);
      kind = a ? K_ADDR : l ? K_LOAD : m ? K_MISO : K_DM;
      if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
        checkValue($sformatf("dut%0d.unexpectedEnable", idx), kind, 0);
      end else begin
        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        checkValue($sformatf("dut%0d.evKind", idx), kind, e.kind);
        checkValue($sformatf("dut%0d.evCycle", idx), cyc, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    monitorOne(0, busA.addrWriteEnable, busA.srParallelLoad, busA.misoBufferEnable, busA.dmWriteEnable);
    monitorOne(1, busB.addrWriteEnable, busB.srParallelLoad, busB.misoBufferEnable, busB.dmWriteEnable);
  end

  task automatic checkBusy(input string tag, input logic exp);
    checkValue({tag, ".busyA"}, int'(busA.busy), int'(exp));
    checkValue({tag, ".busyB"}, int'(busB.busy), int'(exp));
  endtask

  task automatic sendPulses(input int n, output int last);
    last = cyc;
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (GAP - 1) tick();
      last = cyc;
      sclk = 1'b1;
      tick();
      sclk = 1'b0;
    end
  endtask

  // Address phase with rwBit=1, then the data phase; load/MISO cycles differ per DUT.
  task automatic readFlow(input int nPulses, input bit resetOnLast);
    int a;
    int sent;
    int nextPulse;
    int loadCyc[2];
    rw = 1'b1;
    cs = 1'b0;
    tick();
    sendPulses(WIDTH, a);
    pushBoth(K_ADDR, a + 1);
    loadCyc[0] = a + 1 + 1 + 1;
    loadCyc[1] = a + 1 + 1 + 3;
    nextPulse  = a + 6;
    sent       = 0;
    while (sent < nPulses) begin
      for (int i = 0; i < 2; i++) begin
        if (cyc == loadCyc[i])     pushEv(i, K_LOAD, cyc);
        else if (cyc > loadCyc[i]) pushEv(i, K_MISO, cyc);
      end
      if (cyc == nextPulse) begin
        sclk = 1'b1;
        sent++;
        nextPulse += GAP;
        if (sent == nPulses && resetOnLast) reset = 1'b1;
      end
      tick();
      sclk  = 1'b0;
      reset = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
    $fatal(1);
  end

  initial begin
    int a;
    int d;
    int x;

    // Reset held with cs low and pulses toggling.
    reset = 1'b1;
    cs    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sclk = (i % 2 == 1);
      tick();
    end
    sclk = 1'b0;
    checkBusy("reset", 1'b0);
    checkValue("reset.addrWeA", int'(busA.addrWriteEnable), 0);
    checkValue("reset.loadA", int'(busA.srParallelLoad), 0);
    checkValue("reset.misoA", int'(busA.misoBufferEnable), 0);
    checkValue("reset.dmWeA", int'(busA.dmWriteEnable), 0);
    reset = 1'b0;
    tick();
    checkBusy("afterReset", 1'b1);
    cs = 1'b1;
    tick();
    checkBusy("deselect", 1'b0);

    // Write transaction.
    rw = 1'b0;
    cs = 1'b0;
    tick();
    sendPulses(WIDTH, a);
    pushBoth(K_ADDR, a + 1);
    checkValue("write.addrWeA", int'(busA.addrWriteEnable), 1);
    repeat (GAP - 1) tick();
    sendPulses(WIDTH, d);
    pushBoth(K_DM, d + 1);
    checkValue("write.dmWeB", int'(busB.dmWriteEnable), 1);
    tick();
    sendPulses(3, x);
    checkBusy("write.done", 1'b1);
    cs = 1'b1;
    tick();
    checkBusy("write.deselect", 1'b0);

    // Read transaction through to DONE.
    readFlow(WIDTH, 1'b0);
    checkValue("read.misoOffA", int'(busA.misoBufferEnable), 0);
    checkValue("read.misoOffB", int'(busB.misoBufferEnable), 0);
    checkBusy("read.done", 1'b1);
    cs = 1'b1;
    tick();
    checkBusy("read.deselect", 1'b0);

    // Abort after 5 address pulses, then a full address phase.
    rw = 1'b0;
    cs = 1'b0;
    tick();
    sendPulses(5, x);
    cs = 1'b1;
    tick();
    checkBusy("abort", 1'b0);
    cs = 1'b0;
    tick();
    sendPulses(WIDTH, a);
    pushBoth(K_ADDR, a + 1);
    cs = 1'b1;
    tick();
    checkBusy("abort.deselect", 1'b0);

    // Reset coinciding with the 4th data pulse.
    readFlow(4, 1'b1);
    checkValue("midReset.misoA", int'(busA.misoBufferEnable), 0);
    checkValue("midReset.misoB", int'(busB.misoBufferEnable), 0);
    checkBusy("midReset", 1'b0);
    cs = 1'b1;
    tick();

    // Deselect on the same cycle as the final address pulse.
    rw = 1'b1;
    cs = 1'b0;
    tick();
    sendPulses(WIDTH - 1, x);
    repeat (GAP - 1) tick();
    sclk = 1'b1;
    cs   = 1'b1;
    tick();
    sclk = 1'b0;
    checkBusy("csWithLastPulse", 1'b0);
    repeat (4) tick();

    checkValue("queueA.empty", q0.size(), 0);
    checkValue("queueB.empty", q1.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spi_transaction_fsm.md
Name: spi_transaction_fsm

Overview:
Control FSM for the SPI memory datapath. It sits downstream of the shift register and the input conditioners, and consumes the conditioned chip-select, the SCLK rising-edge pulse and the shift register's R/W bit. It sequences address capture, the memory read or write, and the MISO drive, producing the shift register's parallelLoad, the address latch enable, the data memory write enable and the MISO tri-state buffer enable.

Parameters:
WIDTH, 8, bits per SPI phase (7 address bits + 1 R/W bit, then WIDTH data bits)
WAIT_CYCLES, 1, clk cycles spent in READ_WAIT for the data memory read to settle (legal values 1..15)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
sclkPosEdge  input  1  one-clk-wide pulse per SCLK rising edge (input conditioner output)
csConditioned  input  1  conditioned chip select, active low (1 = deselected)
rwBit  input  1  shift register parallelDataOut[0]; 1 = read, 0 = write
srParallelLoad  output  1  parallelLoad to the shift register
addrWriteEnable  output  1  address latch enable
dmWriteEnable  output  1  data memory write enable
misoBufferEnable  output  1  MISO tri-state enable
busy  output  1  high in every state except IDLE

Behaviour:
- States: IDLE, GET_ADDR, GOT_ADDR, READ_WAIT, READ_LOAD, READ_SEND, WRITE_GET, WRITE_DM, DONE.
- The outputs are Moore outputs, decoded only from the state register:
  - addrWriteEnable = 1 only in GOT_ADDR.
  - srParallelLoad = 1 only in READ_LOAD.
  - misoBufferEnable = 1 only in READ_SEND.
  - dmWriteEnable = 1 only in WRITE_DM.
  - busy = (state != IDLE).
- Reset: on a clk edge with reset=1, go to IDLE and clear bitCount and waitCount. All outputs are 0 from the next cycle. Reset has priority over every other condition, including mid-transaction.
- Deselect: csConditioned=1 in any non-IDLE state sends the FSM to IDLE on the next edge and clears the counters. This has priority over sclkPosEdge and every other transition.
- IDLE: stays in IDLE while csConditioned=1. When csConditioned=0, go to GET_ADDR with bitCount=0. sclkPosEdge is ignored in IDLE.
- Bit counting: bitCount has width clog2(WIDTH+1). It is active in GET_ADDR, WRITE_GET and READ_SEND.
  - Each sclkPosEdge increments it.
  - A pulse arriving with bitCount==WIDTH-1 causes the state exit and clears bitCount to 0.
  - Clk cycles with no pulse leave bitCount unchanged.
- GET_ADDR: after the WIDTH-th pulse, go to GOT_ADDR. The shift register updates on the same edge, so rwBit is valid while the FSM is in GOT_ADDR.
- GOT_ADDR (exactly 1 cycle): go to READ_WAIT if rwBit=1, otherwise to WRITE_GET.
- READ_WAIT: lasts exactly WAIT_CYCLES cycles, counted by waitCount (4 bits). Then go to READ_LOAD.
- READ_LOAD (exactly 1 cycle): then go to READ_SEND.
- READ_SEND: after WIDTH pulses, go to DONE.
- WRITE_GET: after WIDTH pulses, go to WRITE_DM.
- WRITE_DM (exactly 1 cycle): then go to DONE.
- DONE: all outputs 0 and busy=1. sclkPosEdge is ignored. Leave DONE only when csConditioned=1, going to IDLE.
- Each enable pulse is therefore exactly one clk wide, and at most one enable is high in any cycle.
- A pulse arriving in GOT_ADDR, READ_WAIT, READ_LOAD or WRITE_DM is dropped. It is not counted.
- Latencies:
  - From the WIDTH-th address pulse edge, addrWriteEnable is high for the next cycle.
  - For a read, srParallelLoad rises 1+WAIT_CYCLES cycles after addrWriteEnable.
  - For a write, dmWriteEnable is high the cycle after the WIDTH-th data pulse.

Test Plan:
1. Reset with csConditioned=0 and pulses toggling → IDLE; all outputs 0 and busy=0 on the cycle after reset; after reset drops and cs stays low, busy=1 on the next edge.
2. Write: cs low, then 8 pulses (every 20 clk) with rwBit=0 at GOT_ADDR → addrWriteEnable high for 1 cycle; then 8 more pulses → dmWriteEnable high for exactly 1 cycle after the 16th pulse; no further pulses on extra SCLK; cs high → busy=0 on the next cycle.
3. Read with WAIT_CYCLES=1: 8 pulses with rwBit=1 → addrWriteEnable 1 cycle, then 1 idle cycle, then srParallelLoad 1 cycle, then misoBufferEnable high through the 8th following pulse and low on the cycle after it; dmWriteEnable stays 0 throughout.
4. Abort: cs raised after 5 address pulses → IDLE next edge with no enable asserted; cs lowered again with 8 pulses → addrWriteEnable fires after the 8th pulse, not the 3rd (confirms bitCount was cleared).
5. Reset mid-READ_SEND (after 3 pulses), same cycle as a pulse → misoBufferEnable=0 and busy=0 on the next cycle; the pulse is not counted.
6. Simultaneous cs=1 and 8th address pulse in GET_ADDR → IDLE; addrWriteEnable never asserts. Also rerun scenario 3 with WAIT_CYCLES=3 → srParallelLoad rises 4 cycles after addrWriteEnable.
